// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the UART program loader.
// Imported by the receiver, the interface users and the loader top.
package imem_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'h55;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Signal bundle between the board UART pin, the loader and the imem write port.
// The loader is the slave side; the top level (or a bench) is the master side.
interface imem_loader_if #(
  parameter int ADDR_W = 6
);

  logic              rx;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    output rx,
    input  imem_we, imem_addr, imem_wdata, cpu_reset, busy, done, error
  );

  modport slave (
    input  rx,
    output imem_we, imem_addr, imem_wdata, cpu_reset, busy, done, error
  );

endinterface

// File: rtl/imem_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, falling-edge start detection,
// mid-bit sampling, one-cycle rx_valid or rx_ferr pulse at the stop-bit centre.
module uart_rx
  import imem_loader_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_ferr
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(DIV / 2 - 1);

  rx_state_t        r_state;
  rx_state_t        w_next;
  logic [1:0]       r_sync;
  logic             r_rxPrev;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bitIdx;
  logic [7:0]       r_shift;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_ferr;
  logic             w_rxs;
  logic             w_fall;
  logic             w_tick;
  logic             w_halfTick;

  assign w_rxs      = r_sync[1];
  assign w_fall     = r_rxPrev & ~w_rxs;
  assign w_tick     = (r_cnt == BIT_END);
  assign w_halfTick = (r_cnt == HALF_END);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= RX_IDLE;
    else        r_state <= w_next;
  end

  // A start edge that is high again at half a bit is treated as a glitch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      RX_IDLE:  if (w_fall) w_next = RX_START;
      RX_START: if (w_halfTick) w_next = w_rxs ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_tick && (r_bitIdx == 3'd7)) w_next = RX_STOP;
      RX_STOP:  if (w_tick) w_next = RX_IDLE;
      default:  w_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync   <= 2'b11;
      r_rxPrev <= 1'b1;
      r_cnt    <= '0;
      r_bitIdx <= '0;
      r_shift  <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      r_sync   <= {r_sync[0], rx};
      r_rxPrev <= w_rxs;
      r_valid  <= 1'b0;
      r_ferr   <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          r_cnt    <= '0;
          r_bitIdx <= '0;
        end
        RX_START: r_cnt <= w_halfTick ? '0 : r_cnt + 1'b1;
        RX_DATA: begin
          if (w_tick) begin
            r_cnt    <= '0;
            r_shift  <= {w_rxs, r_shift[7:1]};
            r_bitIdx <= r_bitIdx + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (w_tick) begin
            r_cnt <= '0;
            if (w_rxs) begin
              r_valid <= 1'b1;
              r_data  <= r_shift;
            end else begin
              r_ferr <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign rx_valid = r_valid;
  assign rx_data  = r_data;
  assign rx_ferr  = r_ferr;

endmodule

// File: rtl/imem_loader.sv
// Program loader: parses sync/length/data/checksum frames from the UART and
// writes words into imem, holding the core in reset until a frame checks out.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115_200,
  parameter int ADDR_W    = 6,
  parameter int MAX_WORDS = 64
) (
  input  logic         clk,
  input  logic         reset,
  imem_loader_if.slave bus
);

  state_t            r_state;
  state_t            w_next;
  logic              w_rxValid;
  logic [7:0]        w_rxData;
  logic              w_rxFerr;
  logic [7:0]        r_lenLo;
  logic [15:0]       r_len;
  logic [15:0]       r_wordsDone;
  logic [1:0]        r_byteIdx;
  logic [23:0]       r_word;
  logic [7:0]        r_sum;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_nextAddr;
  logic [31:0]       r_wdata;
  logic [15:0]       w_len;
  logic              w_active;
  logic              w_lastWord;

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_rx (
    .clk      (clk),
    .reset    (reset),
    .rx       (bus.rx),
    .rx_valid (w_rxValid),
    .rx_data  (w_rxData),
    .rx_ferr  (w_rxFerr)
  );

  assign w_len      = {w_rxData, r_lenLo};
  assign w_active   = (r_state == LEN_LO) || (r_state == LEN_HI) ||
                      (r_state == DATA)   || (r_state == CSUM);
  assign w_lastWord = (r_byteIdx == 2'd3) && ((r_wordsDone + 16'd1) == r_len);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Framing errors only matter inside a frame; idle/finished states wait for sync.
  always_comb begin
    w_next = r_state;
    if (w_rxFerr && w_active) begin
      w_next = ERR;
    end else if (w_rxValid) begin
      unique case (r_state)
        IDLE, DONE, ERR: if (w_rxData == SYNC_BYTE) w_next = LEN_LO;
        LEN_LO:          w_next = LEN_HI;
        LEN_HI: begin
          if (w_len > 16'(MAX_WORDS)) w_next = ERR;
          else if (w_len == 16'd0)    w_next = CSUM;
          else                        w_next = DATA;
        end
        DATA:    if (w_lastWord) w_next = CSUM;
        CSUM:    w_next = (w_rxData == r_sum) ? DONE : ERR;
        default: w_next = IDLE;
      endcase
    end
  end

  // imem_addr shows the address of the last write; r_nextAddr is where the next goes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lenLo     <= '0;
      r_len       <= '0;
      r_wordsDone <= '0;
      r_byteIdx   <= '0;
      r_word      <= '0;
      r_sum       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_nextAddr  <= '0;
      r_wdata     <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_rxValid) begin
        case (r_state)
          IDLE, DONE, ERR: begin
            if (w_rxData == SYNC_BYTE) begin
              r_sum      <= '0;
              r_addr     <= '0;
              r_nextAddr <= '0;
            end
          end
          LEN_LO: r_lenLo <= w_rxData;
          LEN_HI: begin
            r_len       <= w_len;
            r_wordsDone <= '0;
            r_byteIdx   <= '0;
          end
          DATA: begin
            r_sum     <= r_sum + w_rxData;
            r_byteIdx <= r_byteIdx + 1'b1;
            case (r_byteIdx)
              2'd0: r_word[7:0]   <= w_rxData;
              2'd1: r_word[15:8]  <= w_rxData;
              2'd2: r_word[23:16] <= w_rxData;
              default: begin
                r_we        <= 1'b1;
                r_addr      <= r_nextAddr;
                r_nextAddr  <= r_nextAddr + 1'b1;
                r_wdata     <= {w_rxData, r_word};
                r_wordsDone <= r_wordsDone + 16'd1;
              end
            endcase
          end
          default: r_lenLo <= r_lenLo;
        endcase
      end
    end
  end

  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign bus.cpu_reset  = (r_state != DONE);
  assign bus.busy       = w_active;
  assign bus.done       = (r_state == DONE);
  assign bus.error      = (r_state == ERR);

endmodule

// File: doc/imem_loader.md
# imem_loader

Hardware program loader for the RV32I core: receives a framed program image over an 8N1 UART line and writes it word-by-word into instruction memory while holding the CPU in reset. When the checksum matches, it releases the CPU. It sits between the board UART pin and the write port of `imem`, alongside `top`, and replaces file-based preloading on silicon.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000: clock frequency in Hz.
- `BAUD`, 115_200: UART bit rate. `DIV = CLK_FREQ/BAUD` clocks per bit; `DIV` must be ≥ 4.
- `ADDR_W`, 6: imem word-address width.
- `MAX_WORDS`, 64: largest accepted image, in words. Must be ≤ 2**ADDR_W.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `rx`  in  1  UART serial input, idle high. Asynchronous to `clk`.
- `imem_we`  out  1  one-cycle write strobe to imem.
- `imem_addr`  out  ADDR_W  word index being written.
- `imem_wdata`  out  32  instruction word.
- `cpu_reset`  out  1  active-high reset to the core. Held at 1 until a successful load.
- `busy`  out  1  a frame is in progress (state is not IDLE, DONE or ERR).
- `done`  out  1  last frame loaded and checksum matched.
- `error`  out  1  last frame failed.

## Operation
- Frame format, bytes in this order:
  - sync byte `0x55`;
  - word count N as two bytes, LSB first;
  - N×4 data bytes, each word little-endian;
  - one checksum byte = 8-bit sum of all data bytes (sync and count bytes excluded).
- UART receive:
  - `rx` passes through a 2-flop synchronizer.
  - A falling edge starts a bit counter.
  - The start bit is re-checked at DIV/2. If it is high, the event is a glitch: discard it and return to idle.
  - 8 data bits are sampled LSB first at bit centres, then the stop bit.
  - Stop bit high → `rx_valid` pulses 1 cycle with `rx_data`.
  - Stop bit low → `rx_ferr` pulses 1 cycle instead.
- FSM states and transitions:
  - IDLE: on byte `0x55` → LEN_LO. Any other byte is ignored. `rx_ferr` is ignored.
  - LEN_LO → LEN_HI.
  - LEN_HI: if N > MAX_WORDS → ERR. If N == 0 → CSUM. Otherwise → DATA.
  - DATA: a 2-bit byte counter assembles the word. On the 4th byte, pulse `imem_we` at the current `imem_addr` and add the bytes to the running sum. After word N → CSUM.
  - CSUM: byte equals the running sum → DONE. Otherwise → ERR.
  - DONE and ERR: a new `0x55` clears `done`/`error`, asserts `cpu_reset`, zeroes the word address and the sum, and goes to LEN_LO.
- `rx_ferr` in any state except IDLE, DONE or ERR → ERR.
- `cpu_reset` is 0 only in DONE.
- ERR keeps the core in reset. Words already written stay written; there is no rollback.
- Arithmetic:
  - Checksum is 8-bit and wraps modulo 256.
  - Word count is 16-bit.
  - `imem_addr` increments after each write. It never wraps, because N ≤ MAX_WORDS ≤ 2**ADDR_W.

## Timing
- Reset values: `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_reset`=1, `busy`=0, `done`=0, `error`=0. FSM is in IDLE and the UART receiver is idle.
- Reset asserted mid-frame: all outputs return to the reset values immediately (asynchronously). The partial frame is abandoned.
- `rx_valid` and `rx_ferr` fire at the stop-bit centre: about 9.5×DIV clocks after the start edge, plus 2 clocks of synchronizer latency.
- `imem_we` is high exactly 1 cycle, the cycle after the 4th byte's `rx_valid`. `imem_addr` and `imem_wdata` are stable during that cycle and are held until the next write.
- The cycle after the checksum byte's `rx_valid`: `done` (or `error`) rises, and `cpu_reset` falls in the same edge.
- Back-to-back bytes with a single stop bit are accepted; the FSM consumes one byte per `rx_valid`, with no backpressure.

## Structure
- `imem_loader_pkg`: state enum (IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR) and constant `SYNC_BYTE = 8'h55`.
- Sub-module `uart_rx` (params CLK_FREQ, BAUD; ports clk, reset, rx, rx_valid, rx_data[7:0], rx_ferr). It contains the synchronizer and the bit timing.
- `imem_loader` itself holds the frame FSM, the word assembler, the checksum and the address counter.

## Test plan
Bench parameters: CLK_FREQ=1_000_000, BAUD=100_000 (DIV=10), MAX_WORDS=64.
- Load two words: send `55 02 00 13 00 50 06 93 05 90 01 92` → writes addr0=0x06500013 and addr1=0x01900593, each `imem_we` 1 cycle wide. Then `done`=1 and `cpu_reset`=0.
- Bad checksum: same frame ending `93` → both writes occur, then `error`=1, `done`=0, `cpu_reset` stays 1.
- Garbage before sync: `00 FF 12` then the valid frame → no effect before `55`, then the same result as the two-word load.
- Empty image: `55 00 00 00` → no `imem_we`, `done`=1. Oversize image: `55 41 00` → `error`=1 right after the third byte, no writes.
- Framing error: stop bit driven low on the 2nd data byte → `error`=1. A following valid frame recovers to `done`=1.
- Mid-frame reset: pull `reset` low during DATA → all outputs at reset values within the same cycle. After release, a fresh frame loads from addr 0.
